// File: rtl/window_sum_valid_pipe.sv
// rtl/window_sum_valid_pipe.sv - pipelined window adder tree with frame-position valid tagging
module window_sum_valid_pipe #(
   parameter int winRow   = 3,
   parameter int winCol   = 3,
   parameter int imCol    = 640,
   parameter int imRow    = 480,
   parameter int bitwidth = 8,
   localparam int N  = winRow * winCol,
   localparam int SW = bitwidth + $clog2(N),
   localparam int L  = $clog2(N)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  frameStart,
   input  logic [N*bitwidth-1:0] windowIn,
   output logic [SW-1:0]         sumOut,
   output logic                  sumValid,
   output logic                  frameDone
);

   // Operand count of tree level l and its offset in the flattened tree storage.
   function automatic int lvl_cnt(input int l);
      return (N + (1 << l) - 1) >> l;
   endfunction

   function automatic int lvl_off(input int l);
      int o;
      o = 0;
      for (int k = 0; k < l; k++) o += lvl_cnt(k);
      return o;
   endfunction

   localparam int TOT = lvl_off(L + 1);
   localparam int CW  = $clog2(imCol + 1);
   localparam int RW  = $clog2(imRow + 1);

   typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [CW-1:0]   fill_cnt;
   logic [RW-1:0]   row;
   logic [L-1:0]    vld;
   logic [L-1:0]    lst;
   logic [SW-1:0]   tree [TOT];
   logic            tag_vld;
   logic            tag_lst;

   always_comb begin
      tag_vld = 1'b0;
      tag_lst = 1'b0;
      if (state == ACTIVE) begin
         tag_vld = (row >= RW'(winRow - 1)) && (col >= CW'(winCol - 1));
         tag_lst = (row == RW'(imRow - 1)) && (col == CW'(imCol - 1));
      end
   end

   assign sumOut = tree[TOT-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         fill_cnt  <= '0;
         vld       <= '0;
         lst       <= '0;
         sumValid  <= 1'b0;
         frameDone <= 1'b0;
         for (int i = 0; i < TOT; i++) tree[i] <= '0;
      end else if (!enable) begin
         sumValid  <= 1'b0;
         frameDone <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++)
            tree[k] <= SW'(windowIn[k*bitwidth +: bitwidth]);
         // Odd trailing operand of a level passes straight through to the next.
         for (int l = 1; l <= L; l++) begin
            for (int i = 0; i < lvl_cnt(l); i++) begin
               if (2*i + 1 < lvl_cnt(l-1))
                  tree[lvl_off(l) + i] <= tree[lvl_off(l-1) + 2*i] + tree[lvl_off(l-1) + 2*i + 1];
               else
                  tree[lvl_off(l) + i] <= tree[lvl_off(l-1) + 2*i];
            end
         end

         if (frameStart) begin
            vld       <= '0;
            lst       <= '0;
            sumValid  <= 1'b0;
            frameDone <= 1'b0;
            fill_cnt  <= CW'(1);
            row       <= '0;
            col       <= '0;
            state     <= (imCol == 1) ? ACTIVE : FILL;
         end else begin
            vld       <= (vld << 1) | L'(tag_vld);
            lst       <= (lst << 1) | L'(tag_lst);
            sumValid  <= vld[L-1];
            frameDone <= vld[L-1] & lst[L-1];
            case (state)
               FILL: begin
                  if (fill_cnt == CW'(imCol - 1)) begin
                     state <= ACTIVE;
                     row   <= '0;
                     col   <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + CW'(1);
                  end
               end
               ACTIVE: begin
                  if (tag_lst) state <= DONE;
                  if (col == CW'(imCol - 1)) begin
                     col <= '0;
                     row <= row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_window_sum_valid_pipe.sv
// tb/tb_window_sum_valid_pipe.sv - scoreboard bench for window_sum_valid_pipe on an 8x6 image
module tb_window_sum_valid_pipe;

   localparam int WR  = 3;
   localparam int WC  = 3;
   localparam int IMC = 8;
   localparam int IMR = 6;
   localparam int BW  = 8;
   localparam int N   = WR * WC;
   localparam int SW  = 12;
   localparam int L   = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic            frameStart = 1'b0;
   logic [N*BW-1:0] windowIn = '0;
   logic [SW-1:0]   sumOut;
   logic            sumValid;
   logic            frameDone;

   window_sum_valid_pipe #(
      .winRow(WR), .winCol(WC), .imCol(IMC), .imRow(IMR), .bitwidth(BW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .frameStart(frameStart),
      .windowIn(windowIn),
      .sumOut(sumOut),
      .sumValid(sumValid),
      .frameDone(frameDone)
   );

   always #5 clock = ~clock;

   typedef struct {
      int sum;
      bit v;
      bit l;
      int due;
   } cap_t;

   cap_t q[$];
   int   vecs = 0;
   int   errs = 0;
   int   ecnt = 0;
   int   base = -1;
   int   exp_sum = 0;
   bit   exp_v;
   bit   exp_l;
   int   pulses;
   int   dones;
   int   first_edge;
   int   mode = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at the falling edge, predict, then check at the next falling edge.
   task automatic tick(input bit rst, input bit en, input bit fs);
      int   s;
      int   p;
      int   px;
      cap_t c;
      s = 0;
      reset      = rst;
      enable     = en;
      frameStart = fs;
      for (int k = 0; k < N; k++) begin
         px = (mode == 1) ? 255 : (mode == 2) ? k + 1 : int'($urandom_range(0, 255));
         windowIn[k*BW +: BW] = BW'(px);
         s += px;
      end
      exp_v = 1'b0;
      exp_l = 1'b0;
      if (rst) begin
         q.delete();
         base    = -1;
         exp_sum = 0;
      end else if (en) begin
         ecnt++;
         c.sum = s;
         c.v   = 1'b0;
         c.l   = 1'b0;
         c.due = ecnt + L;
         if (fs) begin
            base = ecnt;
            foreach (q[i]) begin
               q[i].v = 1'b0;
               q[i].l = 1'b0;
            end
         end else if (base >= 0) begin
            p = ecnt - base - IMC;
            if (p >= 0 && p < IMC * IMR) begin
               c.v = (p / IMC >= WR - 1) && (p % IMC >= WC - 1);
               c.l = (p == IMC * IMR - 1);
            end
         end
         q.push_back(c);
         if (q[0].due == ecnt) begin
            c       = q.pop_front();
            exp_sum = c.sum;
            exp_v   = c.v;
            exp_l   = c.l;
         end
      end
      @(posedge clock);
      @(negedge clock);
      chk("sumOut", 32'(sumOut), exp_sum);
      chk("sumValid", 32'(sumValid), 32'(exp_v));
      chk("frameDone", 32'(frameDone), 32'(exp_v && exp_l));
      if (sumValid === 1'b1) begin
         pulses++;
         if (first_edge < 0) first_edge = ecnt - base + 1;
      end
      if (frameDone === 1'b1) dones++;
   endtask

   initial begin
      // reset state
      tick(1, 1, 0);
      tick(1, 0, 0);

      // all-255 frame, continuous enable, then drain and idle in DONE
      mode = 1; pulses = 0; dones = 0; first_edge = -1;
      tick(0, 1, 1);
      repeat (64) tick(0, 1, 0);
      chk("first_valid_edge", first_edge, 31);
      chk("frame1_pulses", pulses, 24);
      chk("frame1_done", dones, 1);

      // elements 1..9 in every window
      mode = 2; pulses = 0; dones = 0;
      tick(0, 1, 1);
      repeat (62) tick(0, 1, 0);
      chk("frame2_pulses", pulses, 24);
      chk("frame2_done", dones, 1);

      // random pixels with enable toggling
      mode = 0; pulses = 0; dones = 0;
      tick(0, 1, 1);
      tick(0, 0, 0);
      repeat (64) begin
         tick(0, 1, 0);
         tick(0, 0, 0);
      end
      chk("frame3_pulses", pulses, 24);
      chk("frame3_done", dones, 1);

      // restart at ACTIVE position (3,4)
      tick(0, 1, 1);
      repeat (35) tick(0, 1, 0);
      pulses = 0; dones = 0;
      tick(0, 1, 1);
      repeat (64) tick(0, 1, 0);
      chk("restart_pulses", pulses, 24);
      chk("restart_done", dones, 1);

      // reset mid-ACTIVE with a full pipeline, then enables without frameStart
      tick(0, 1, 1);
      repeat (40) tick(0, 1, 0);
      pulses = 0; dones = 0;
      tick(1, 1, 1);
      repeat (20) tick(0, 1, 0);
      chk("post_reset_pulses", pulses, 0);
      chk("post_reset_done", dones, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
